ps2_key_decoder: RTL and testbench

- Parametrised PS/2 Set-2 scan-code decoder; successor to the single-FSM forward/back accel decoder.
- Sits between PS2_Controller (received_data / received_data_en) and game logic.
- Tracks press/hold/release of NUM_KEYS configurable keys, including E0-extended keys.
- Handles the E1 Pause sequence and prefix timeouts; outputs a held-key bitmap, one-cycle make/break pulses and a registered 2-bit accel code.

---
 rtl/ps2_key_decoder.sv | 184 ++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scan-code decoder: tracks NUM_KEYS keys (E0-extended included), skips E1 Pause, times out stale prefixes.
// Optional PS2_ERR_CLEAR_EN: in IDLE, bytes 00/FF/AA release every held key.

package ps2_key_decoder_pkg;
   typedef struct packed {
      logic       vld;   // completed make/break
      logic       brk;
      logic       clr;   // release-all request
      logic [8:0] code;  // {ext, scan code}
   } ps2_evt_t;
endpackage

module ps2_key_slot
   import ps2_key_decoder_pkg::*;
#(
   parameter logic [8:0] CODE = 9'h000
) (
   input  logic     CLOCK_50,
   input  logic     reset,
   input  ps2_evt_t evt,
   output logic     held_nxt,
   output logic     held,
   output logic     make,
   output logic     brk
);

   always_comb begin
      held_nxt = held;
      if (evt.clr)
         held_nxt = 1'b0;
      else if (evt.vld && evt.code == CODE)
         held_nxt = ~evt.brk;
   end

   // Edge pulses fall out of comparing next vs current, so typematic repeats are silent.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         held <= 1'b0;
         make <= 1'b0;
         brk  <= 1'b0;
      end else begin
         held <= held_nxt;
         make <= held_nxt & ~held;
         brk  <= held & ~held_nxt;
      end
   end

endmodule

module ps2_key_decoder
   import ps2_key_decoder_pkg::*;
#(
   parameter int                    NUM_KEYS       = 4,
   parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = {9'h074, 9'h06B, 9'h072, 9'h073},
   parameter int                    FWD_IDX        = 0,
   parameter int                    BACK_IDX       = 1,
   parameter int                    TIMEOUT_CYCLES = 2500000
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic [7:0]          ps2_key_data,
   input  logic                ps2_key_pressed,
   output logic [NUM_KEYS-1:0] key_held,
   output logic [NUM_KEYS-1:0] key_make,
   output logic [NUM_KEYS-1:0] key_break,
   output logic [1:0]          accel
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

   state_t              state;
   logic [2:0]          skip_cnt;
   logic [TW-1:0]       tmo_cnt;
   logic                is_prefix;
   logic                is_err;
   ps2_evt_t            evt;
   logic [NUM_KEYS-1:0] held_nxt;

   assign is_prefix = ps2_key_data inside {8'hE0, 8'hF0, 8'hE1};

`ifdef PS2_ERR_CLEAR_EN
   assign is_err = ps2_key_data inside {8'h00, 8'hFF, 8'hAA};
`else
   assign is_err = 1'b0;
`endif

   always_comb begin
      evt = '0;
      if (ps2_key_pressed) begin
         case (state)
            IDLE: begin
               if (!is_prefix) begin
                  if (is_err) begin
                     evt.clr = 1'b1;
                  end else begin
                     evt.vld  = 1'b1;
                     evt.code = {1'b0, ps2_key_data};
                  end
               end
            end
            EXT: begin
               if (!is_prefix) begin
                  evt.vld  = 1'b1;
                  evt.code = {1'b1, ps2_key_data};
               end
            end
            BRK: begin
               evt.vld  = 1'b1;
               evt.brk  = 1'b1;
               evt.code = {1'b0, ps2_key_data};
            end
            EXT_BRK: begin
               evt.vld  = 1'b1;
               evt.brk  = 1'b1;
               evt.code = {1'b1, ps2_key_data};
            end
            default: ;
         endcase
      end
   end

   // A strobe always wins over timeout expiry; the counter only runs mid-sequence.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         skip_cnt <= 3'd0;
         tmo_cnt  <= '0;
      end else if (ps2_key_pressed) begin
         tmo_cnt <= '0;
         case (state)
            IDLE, EXT: begin
               case (ps2_key_data)
                  8'hE0:   state <= EXT;
                  8'hF0:   state <= (state == IDLE) ? BRK : EXT_BRK;
                  8'hE1: begin
                     state    <= SKIP;
                     skip_cnt <= 3'd7;
                  end
                  default: state <= IDLE;
               endcase
            end
            BRK, EXT_BRK: state <= IDLE;
            SKIP: begin
               skip_cnt <= skip_cnt - 3'd1;
               if (skip_cnt == 3'd1)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end else if (state != IDLE) begin
         if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state    <= IDLE;
            skip_cnt <= 3'd0;
            tmo_cnt  <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end
      end
   end

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_slot
      ps2_key_slot #(.CODE(KEY_CODES[9*i +: 9])) u_slot (
         .CLOCK_50 (CLOCK_50),
         .reset    (reset),
         .evt      (evt),
         .held_nxt (held_nxt[i]),
         .held     (key_held[i]),
         .make     (key_make[i]),
         .brk      (key_break[i])
      );
   end

   // Built from next-state bits so accel lands in the same cycle as key_held.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset)
         accel <= 2'b00;
      else
         accel <= {held_nxt[FWD_IDX] & ~held_nxt[BACK_IDX],
                   held_nxt[BACK_IDX] & ~held_nxt[FWD_IDX]};
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed vector table, hand-written corner sequences, random bytes vs a sequence-level model.
module tb_ps2_key_decoder;

   localparam int          NK    = 4;
   localparam int          T     = 100;
   localparam logic [35:0] CODES = {9'h074, 9'h175, 9'h072, 9'h073};

   logic          CLOCK_50 = 1'b0;
   logic          reset    = 1'b1;
   logic [7:0]    ps2_key_data = 8'h00;
   logic          ps2_key_pressed = 1'b0;
   logic [NK-1:0] key_held, key_make, key_break;
   logic [1:0]    accel;

   always #5 CLOCK_50 = ~CLOCK_50;

   ps2_key_decoder #(
      .NUM_KEYS(NK), .KEY_CODES(CODES), .FWD_IDX(0), .BACK_IDX(1), .TIMEOUT_CYCLES(T)
   ) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .ps2_key_data(ps2_key_data),
      .ps2_key_pressed(ps2_key_pressed), .key_held(key_held), .key_make(key_make),
      .key_break(key_break), .accel(accel)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: pending prefix bytes, pause bytes left, idle cycles since last strobe.
   logic [NK-1:0] m_held = '0, m_make = '0, m_brk = '0;
   logic [1:0]    m_accel = 2'b00;
   logic [7:0]    seq[$];
   int            m_skip = 0;
   int            m_idle = 0;

   typedef struct {
      logic [7:0]    b;
      logic [NK-1:0] held;
      logic [NK-1:0] make;
      logic [NK-1:0] brk;
      logic [1:0]    accel;
   } vec_t;
   vec_t tv[17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void m_apply(input logic [8:0] code, input logic brk);
      for (int i = 0; i < NK; i++)
         if (CODES[9*i +: 9] == code) m_held[i] = ~brk;
   endfunction

   function automatic bit m_err_byte(input logic [7:0] b);
`ifdef PS2_ERR_CLEAR_EN
      return (b == 8'h00 || b == 8'hFF || b == 8'hAA);
`else
      return (b != b);
`endif
   endfunction

   task automatic m_step(input logic v, input logic [7:0] b);
      logic [NK-1:0] prev;
      logic          ext;
      prev = m_held;
      ext  = (seq.size() > 0) && (seq[0] == 8'hE0);
      if (!v) begin
         if (seq.size() > 0 || m_skip > 0) begin
            m_idle++;
            if (m_idle >= T) begin
               seq.delete();
               m_skip = 0;
               m_idle = 0;
            end
         end
      end else begin
         m_idle = 0;
         if (m_skip > 0) begin
            m_skip--;
         end else if (seq.size() > 0 && seq[seq.size()-1] == 8'hF0) begin
            m_apply({ext, b}, 1'b1);
            seq.delete();
         end else if (b == 8'hE1) begin
            seq.delete();
            m_skip = 7;
         end else if (b == 8'hE0) begin
            seq.delete();
            seq.push_back(b);
         end else if (b == 8'hF0) begin
            seq.push_back(b);
         end else if (seq.size() == 0 && m_err_byte(b)) begin
            m_held = '0;
         end else begin
            m_apply({ext, b}, 1'b0);
            seq.delete();
         end
      end
      m_make  = m_held & ~prev;
      m_brk   = prev & ~m_held;
      m_accel = {m_held[0] & ~m_held[1], m_held[1] & ~m_held[0]};
   endtask

   task automatic step(input logic v, input logic [7:0] b);
      ps2_key_pressed = v;
      ps2_key_data    = v ? b : 8'($urandom);
      @(negedge CLOCK_50);
      ps2_key_pressed = 1'b0;
      m_step(v, b);
      chk("m_held",  key_held,  m_held);
      chk("m_make",  key_make,  m_make);
      chk("m_break", key_break, m_brk);
      chk("m_accel", accel,     m_accel);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 8'h00);
   endtask

   task automatic send(input logic [7:0] b);
      step(1'b1, b);
      idle(1);
   endtask

   initial begin
      tv[0]  = '{8'h73, 4'b0001, 4'b0001, 4'b0000, 2'b10};
      tv[1]  = '{8'hF0, 4'b0001, 4'b0000, 4'b0000, 2'b10};
      tv[2]  = '{8'h73, 4'b0000, 4'b0000, 4'b0001, 2'b00};
      tv[3]  = '{8'hE0, 4'b0000, 4'b0000, 4'b0000, 2'b00};
      tv[4]  = '{8'h75, 4'b0100, 4'b0100, 4'b0000, 2'b00};
      tv[5]  = '{8'hE0, 4'b0100, 4'b0000, 4'b0000, 2'b00};
      tv[6]  = '{8'hF0, 4'b0100, 4'b0000, 4'b0000, 2'b00};
      tv[7]  = '{8'h75, 4'b0000, 4'b0000, 4'b0100, 2'b00};
      tv[8]  = '{8'h75, 4'b0000, 4'b0000, 4'b0000, 2'b00};
      tv[9]  = '{8'h73, 4'b0001, 4'b0001, 4'b0000, 2'b10};
      tv[10] = '{8'h72, 4'b0011, 4'b0010, 4'b0000, 2'b00};
      tv[11] = '{8'h73, 4'b0011, 4'b0000, 4'b0000, 2'b00};
      tv[12] = '{8'h73, 4'b0011, 4'b0000, 4'b0000, 2'b00};
      tv[13] = '{8'hF0, 4'b0011, 4'b0000, 4'b0000, 2'b00};
      tv[14] = '{8'h72, 4'b0001, 4'b0000, 4'b0010, 2'b10};
      tv[15] = '{8'hF0, 4'b0001, 4'b0000, 4'b0000, 2'b10};
      tv[16] = '{8'h73, 4'b0000, 4'b0000, 4'b0001, 2'b00};

      // Reset state
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      chk("rst_held",  key_held,  4'b0000);
      chk("rst_make",  key_make,  4'b0000);
      chk("rst_break", key_break, 4'b0000);
      chk("rst_accel", accel,     2'b00);
      reset = 1'b0;
      idle(2);

      // Directed table: press/release, extended key, conflict, typematic
      for (int i = 0; i < 17; i++) begin
         step(1'b1, tv[i].b);
         chk($sformatf("tv%0d_held", i),  key_held,  tv[i].held);
         chk($sformatf("tv%0d_make", i),  key_make,  tv[i].make);
         chk($sformatf("tv%0d_break", i), key_break, tv[i].brk);
         chk($sformatf("tv%0d_accel", i), accel,     tv[i].accel);
         idle(1);
      end

      // Pause sequence followed by a normal make
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      chk("pause_held", key_held, 4'b0000);
      step(1'b1, 8'h73);
      chk("pause_make", key_make, 4'b0001);
      chk("pause_after", key_held, 4'b0001);
      idle(1);
      send(8'hF0); send(8'h73);

      // Timeout: a full T idle cycles after F0 drops the break prefix
      step(1'b1, 8'hF0);
      idle(T);
      step(1'b1, 8'h73);
      chk("tmo_make", key_make, 4'b0001);
      chk("tmo_held", key_held, 4'b0001);
      idle(1);
      // One cycle short of expiry the break still lands
      step(1'b1, 8'hF0);
      idle(T - 1);
      step(1'b1, 8'h73);
      chk("tmo_edge_break", key_break, 4'b0001);
      chk("tmo_edge_held",  key_held,  4'b0000);
      idle(1);

      // Asynchronous reset mid-sequence
      send(8'h73);
      send(8'hE0);
      #2 reset = 1'b1;
      #1;
      chk("arst_held",  key_held,  4'b0000);
      chk("arst_accel", accel,     2'b00);
      chk("arst_make",  key_make,  4'b0000);
      @(negedge CLOCK_50);
      #2 reset = 1'b0;
      @(negedge CLOCK_50);
      m_held = '0; m_make = '0; m_brk = '0; m_accel = 2'b00;
      seq.delete(); m_skip = 0; m_idle = 0;
      step(1'b1, 8'h73);
      chk("arst_orphan_make", key_make, 4'b0001);
      idle(1);

      // Error bytes while keys 0 and 1 are held
      send(8'h72);
      step(1'b1, 8'hAA);
`ifdef PS2_ERR_CLEAR_EN
      chk("err_held",  key_held,  4'b0000);
      chk("err_break", key_break, 4'b0011);
`else
      chk("err_held",  key_held,  4'b0011);
      chk("err_break", key_break, 4'b0000);
`endif
      idle(1);

      // Random byte stream, occasional gaps around the timeout boundary
      for (int n = 0; n < 500; n++) begin
         logic [7:0] b;
         int         g;
         case ($urandom_range(0, 15))
            0, 1:    b = 8'hE0;
            2, 3:    b = 8'hF0;
            4:       b = 8'h73;
            5:       b = 8'h72;
            6:       b = 8'h75;
            7:       b = 8'h74;
            8:       b = 8'h6B;
            9:       b = 8'hAA;
            10:      b = 8'h00;
            11:      b = 8'hFF;
            12:      b = 8'h73;
            13:      b = 8'h72;
            14:      b = 8'($urandom);
            default: b = 8'hE1;
         endcase
         g = ($urandom_range(0, 19) == 0) ? $urandom_range(T - 2, T + 1) : $urandom_range(0, 3);
         step(1'b1, b);
         idle(g);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
